bcd_to_bin: RTL and testbench
=============================

Name: bcd_to_bin

Overview:
Sequential 8421-BCD to binary converter. It is the inverse of the existing bcd_8421 binary-to-BCD block.
- Accepts six BCD digits (unit through h_hun) over a valid/ready handshake.
- Produces the equivalent 20-bit binary value after a fixed iterative multiply-by-10-accumulate sequence.
- Sits between digit-entry/display logic and binary arithmetic. Used for loop-back checking of bcd_8421 in the seg_595 display path.

Parameters:
DIGITS, 6, number of BCD digits converted; digit 0 = unit, digit DIGITS-1 = h_hun.
DATA_W, 20, binary output width; must satisfy 10^DIGITS-1 < 2^DATA_W.

Ports:
sys_clk  input  1  system clock, all state updates on its rising edge.
sys_rst  input  1  asynchronous, active-high reset.
in_valid  input  1  digit set present on unit..h_hun.
in_ready  output  1  block can accept a digit set (high only in IDLE).
unit  input  4  BCD digit 10^0.
ten  input  4  BCD digit 10^1.
hun  input  4  BCD digit 10^2.
tho  input  4  BCD digit 10^3.
t_tho  input  4  BCD digit 10^4.
h_hun  input  4  BCD digit 10^5.
data  output  DATA_W  converted binary value, held until the next conversion completes.
out_valid  output  1  one-cycle pulse; data is valid and new.
busy  output  1  conversion in progress (CONV or DONE).
err  output  1  invalid digit flag, qualified by out_valid (see Optional Feature).

Behaviour:
- Reset, asynchronous: state=IDLE, data=0, out_valid=0, busy=0, err=0, in_ready=1. The internal accumulator, digit register and counter are cleared.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid=1: capture all six digits into a register, set acc=0, set cnt=DIGITS-1, go to CONV.
  - in_valid=0: stay.
- CONV:
  - Each cycle: acc <= acc*10 + digit[cnt], with acc*10 computed as (acc<<3)+(acc<<1) at DATA_W+4 bits, then truncated to DATA_W.
  - Digits are processed MSB first (h_hun first, unit last).
  - cnt decrements each cycle; on the cycle with cnt==0, go to DONE.
- DONE, one cycle: data <= acc, out_valid=1, go to IDLE.
- Latency: handshake at edge k; out_valid is high in the cycle following edge k+DIGITS+1, i.e. 8 edges after acceptance for DIGITS=6.
- Throughput: one conversion per DIGITS+2 cycles.
- The digit inputs may change freely after the accept edge; only captured values are used.
- in_valid while busy: ignored, no capture, no queuing. The source must hold in_valid until it sees in_ready.
- Overflow: cannot occur for valid BCD; maximum 999999 = 0xF423F. With invalid digits the result wraps modulo 2^DATA_W, with no saturation.
- Reset mid-conversion: immediate abort to IDLE, data cleared, no out_valid.
- data is stable between out_valid pulses.

Optional Feature:
Macro BCD_DIGIT_CHECK_EN.
- Defined:
  - At capture, any digit >9 sets a sticky internal flag.
  - err=flag while out_valid=1, else 0.
  - Conversion still completes with the wrapped arithmetic result.
- Undefined: err is tied to 0 and the check logic is absent. Port list is unchanged.

Decomposition:
Package bcd_pkg holds:
- state enum (IDLE, CONV, DONE)
- DIGIT_W=4
- BCD_MAX=4'd9
- default DIGITS/DATA_W constants, shared with bcd_8421

One natural sub-module: bcd_mac10, a combinational acc*10+digit with DATA_W truncation, reusable and unit-testable alone. All FSM, counter and registers stay in bcd_to_bin.

Test Plan:
1. Digits 9,8,7,6,5,4 (h_hun..unit), one-cycle in_valid -> out_valid exactly 8 edges after accept, data=20'd987654 (0xF1206), err=0.
2. All digits 0 -> data=0. Then all digits 9 -> data=999999 (0xF423F). Back-to-back: second in_valid asserted the cycle after out_valid is accepted.
3. New in_valid with 123456 held during CONV of 987654 -> ignored until IDLE. First result 987654, then 123456 after re-acceptance, in_ready low throughout busy.
4. sys_rst pulsed 3 cycles after accepting 555555 -> outputs at reset values within the reset cycle, no out_valid. A subsequent 000042 yields data=42.
5. Loop-back: bcd_8421 driven with data=20'd987654, its digit outputs fed to bcd_to_bin -> data matches 987654. Repeat for 0, 1, 999999 and 10 random values.
6. With BCD_DIGIT_CHECK_EN, unit=4'hA, others 0 -> out_valid with err=1, data=10. Without the macro -> err=0, data=10.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD <-> binary converters.
// Optional macro BCD_DIGIT_CHECK_EN enables the digit-range flag in bcd_to_bin.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  localparam int DEF_DIGITS = 6;
  localparam int DEF_DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  function automatic logic bcd_bad(
    input logic [DIGIT_W-1:0] d
  );
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + digit, truncated to DATA_W.
// Ports: acc (DATA_W), digit (4) -> result (DATA_W).
module bcd_mac10
  import bcd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0]  acc,
  input  logic [DIGIT_W-1:0] digit,
  output logic [DATA_W-1:0]  result
);

  logic [DATA_W+3:0] ext;
  logic [DATA_W+3:0] wide;
  logic              unused_hi;

  assign ext  = {4'b0, acc};
  // x*10 = x*8 + x*2; invalid digits wrap modulo 2^DATA_W.
  assign wide = (ext << 3) + (ext << 1)
              + {{DATA_W{1'b0}}, digit};

  assign result    = wide[DATA_W-1:0];
  assign unused_hi = ^wide[DATA_W+3:DATA_W];

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 8421-BCD to binary converter, MSB digit first.
// Ports: sys_clk, sys_rst (async high), in_valid/in_ready, unit..h_hun,
//   data, out_valid, busy, err. Macro BCD_DIGIT_CHECK_EN drives err.
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        unit,
  input  logic [3:0]        ten,
  input  logic [3:0]        hun,
  input  logic [3:0]        tho,
  input  logic [3:0]        t_tho,
  input  logic [3:0]        h_hun,
  output logic [DATA_W-1:0] data,
  output logic              out_valid,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t state;
  state_t state_nx;

  logic [DIGITS-1:0][DIGIT_W-1:0] dig;
  logic [CNT_W-1:0]               cnt;
  logic [DATA_W-1:0]              acc;
  logic [DATA_W-1:0]              acc_nx;
  logic                           accept;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && (state == IDLE);

  bcd_mac10 #(
    .DATA_W (DATA_W)
  ) u_mac (
    .acc    (acc),
    .digit  (dig[cnt]),
    .result (acc_nx)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = CONV;
      CONV: if (cnt == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dig       <= '0;
      cnt       <= '0;
      acc       <= '0;
      data      <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dig <= {h_hun, t_tho, tho,
                    hun, ten, unit};
            acc <= '0;
            cnt <= CNT_W'(DIGITS - 1);
          end
        end
        CONV: begin
          acc <= acc_nx;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        DONE: begin
          data      <= acc;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_flag;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      bad_flag <= 1'b0;
    end else if (accept) begin
      bad_flag <= bcd_bad(unit)  | bcd_bad(ten)
                | bcd_bad(hun)   | bcd_bad(tho)
                | bcd_bad(t_tho) | bcd_bad(h_hun);
    end
  end

  assign err = out_valid & bad_flag;
`else
  logic unused_accept;

  assign unused_accept = accept;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin.
// Binary->BCD reference for loop-back is a local function.
module tb_bcd_to_bin;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  unit = '0, ten = '0, hun = '0;
  logic [3:0]  tho = '0, t_tho = '0, h_hun = '0;
  logic [19:0] data;
  logic        out_valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

`ifdef BCD_DIGIT_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  bcd_to_bin dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .unit      (unit),
    .ten       (ten),
    .hun       (hun),
    .tho       (tho),
    .t_tho     (t_tho),
    .h_hun     (h_hun),
    .data      (data),
    .out_valid (out_valid),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic set_dig(input logic [23:0] d);
    {h_hun, t_tho, tho, hun, ten, unit} = d;
  endtask

  // Drive at a negedge; acceptance happens at the next posedge.
  task automatic send(input logic [23:0] d);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge sys_clk);
      n++;
    end
    set_dig(d);
    in_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    set_dig(24'hFFFFFF);
  endtask

  // Counts edges from the accept edge (edge 1) until out_valid.
  task automatic wait_out(output int edges);
    edges = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk);
      #1;
      edges++;
      if (out_valid) return;
    end
    edges = -1;
  endtask

  int e;
  int v;
  logic bad;

  initial begin
    #2;
    chk("rst_data", data, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_err", err, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // 1: basic conversion and latency
    send(24'h987654);
    chk("t1_busy", busy, 1);
    chk("t1_ready", in_ready, 0);
    wait_out(e);
    chk("t1_lat", e, 8);
    chk("t1_data", data, 987654);
    chk("t1_err", err, 0);
    @(posedge sys_clk);
    #1;
    chk("t1_pulse", out_valid, 0);

    // 2: zero, then all nines back to back
    send(24'h000000);
    wait_out(e);
    chk("t2_lat0", e, 8);
    chk("t2_zero", data, 0);
    send(24'h999999);
    wait_out(e);
    chk("t2_lat9", e, 8);
    chk("t2_max", data, 999999);

    // 3: request held during busy is ignored
    send(24'h987654);
    set_dig(24'h123456);
    in_valid = 1'b1;
    bad = 1'b0;
    e = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk);
      #1;
      e++;
      if (out_valid) break;
      if (in_ready || !busy) bad = 1'b1;
    end
    chk("t3_ready_low", bad, 0);
    chk("t3_lat1", e, 8);
    chk("t3_first", data, 987654);
    @(posedge sys_clk);
    #1;
    in_valid = 1'b0;
    set_dig(24'h000000);
    chk("t3_busy2", busy, 1);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("t3_hold", data, 987654);
    e = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk);
      #1;
      if (out_valid) begin
        e = 1;
        break;
      end
    end
    chk("t3_seen2", e, 1);
    chk("t3_second", data, 123456);

    // 4: reset mid-conversion
    send(24'h555555);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    chk("t4_data", data, 0);
    chk("t4_ready", in_ready, 1);
    chk("t4_busy", busy, 0);
    chk("t4_ovalid", out_valid, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(posedge sys_clk);
      #1;
      if (out_valid) bad = 1'b1;
    end
    chk("t4_no_pulse", bad, 0);
    send(24'h000042);
    wait_out(e);
    chk("t4_lat", e, 8);
    chk("t4_42", data, 42);

    // 5: loop-back through a binary->BCD reference
    for (int i = 0; i < 13; i++) begin
      if (i == 0) v = 0;
      else if (i == 1) v = 1;
      else if (i == 2) v = 999999;
      else v = int'($urandom_range(999999, 0));
      send(to_bcd(v));
      wait_out(e);
      chk($sformatf("t5_lat_%0d", v), e, 8);
      chk($sformatf("t5_loop_%0d", v), data, v);
    end

    // 6: invalid digits
    send(24'h00000A);
    wait_out(e);
    chk("t6_data", data, 10);
    chk("t6_err", err, ERR_EXP);
    @(posedge sys_clk);
    #1;
    chk("t6_err_qual", err, 0);
    // 15*111111 = 1666665, wraps to 618089
    send(24'hFFFFFF);
    wait_out(e);
    chk("t6_wrap", data, 618089);
    chk("t6_err_f", err, ERR_EXP);
    send(24'h000001);
    wait_out(e);
    chk("t6_clear", err, 0);
    chk("t6_one", data, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
